prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter BASE0, default 10'd0, SHALL be the program 0 start address.
REQ-002 Parameter BASE1, default 10'd256, SHALL be the program 1 start address.
REQ-003 Parameter BASE2, default 10'd512, SHALL be the program 2 start address.
REQ-004 Parameter TIMEOUT, default 16'hFFFF, SHALL be the RUN-cycle limit before a forced finish.
REQ-005 Clk  input  1  SHALL be the single clock; all state changes on its rising edge only.
REQ-006 Reset  input  1  SHALL be synchronous, active-high.
REQ-007 Go  input  1  SHALL be the request to launch the next program; held high = hold, release = commence.
REQ-008 Done  input  1  SHALL be the core's halt indication for the running program.
REQ-009 FetchStart  output  1  SHALL drive the fetch unit's Start hold (1 = PC frozen).
REQ-010 LoadEn  output  1  SHALL be a one-cycle strobe to load LoadAddr into the PC.
REQ-011 LoadAddr  output  10  SHALL be the base address of the selected program.
REQ-012 ProgIdx  output  2  SHALL be the index (0..2) of the current/next program.
REQ-013 Busy  output  1  SHALL be high in every state except IDLE.
REQ-014 Ack  output  1  SHALL be a one-cycle pulse when a program finishes.
REQ-015 CycleCount  output  16  SHALL be the RUN-cycle count of the current/last program.
REQ-016 TimedOut  output  1  SHALL flag that the last program ended by timeout.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, HOLD, RUN, FINISH, one state register.
REQ-018 IDLE: FetchStart=1, LoadEn=0; Go=1 -> LOAD next cycle; otherwise stay.
REQ-019 LOAD (exactly one cycle): LoadEn=1, FetchStart=1, CycleCount<=0, TimedOut<=0; -> HOLD.
REQ-020 LoadAddr SHALL be combinational from ProgIdx: 0->BASE0, 1->BASE1, 2->BASE2, 3->BASE0.
REQ-021 HOLD: FetchStart=1; Go=0 -> RUN next cycle; Go=1 -> stay.
REQ-022 RUN: FetchStart=0; CycleCount increments by 1 each RUN cycle, including the cycle Done is sampled high.
REQ-023 RUN: Done=1 -> FINISH with TimedOut=0.
REQ-024 RUN: Done=0 and CycleCount==TIMEOUT -> FINISH with TimedOut<=1; CycleCount SHALL NOT wrap past TIMEOUT.
REQ-025 Done=1 and timeout in the same cycle: Done SHALL win (TimedOut=0).
REQ-026 FINISH (exactly one cycle): Ack=1, FetchStart=1, ProgIdx <= ProgIdx+1 wrapping 2->0; -> IDLE.
REQ-027 Go SHALL be ignored in RUN and FINISH; Done SHALL be ignored outside RUN.
REQ-028 CycleCount and TimedOut SHALL hold their values from FINISH until the next LOAD.
REQ-029 Ack, LoadEn SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per program.

Reset
REQ-030 Reset=1 SHALL, at the next edge and from any state (including mid-RUN), force state=IDLE, ProgIdx=0, CycleCount=0, TimedOut=0.
REQ-031 During and after reset: FetchStart=1, LoadEn=0, Ack=0, Busy=0, LoadAddr=BASE0.
REQ-032 Reset SHALL take priority over Go and Done in the same cycle.

Verification
REQ-033 Reset; Go=1 for 3 cycles then 0; Done pulse after 10 RUN cycles -> LoadEn once with LoadAddr=0, CycleCount=10, Ack one cycle, ProgIdx=1, TimedOut=0.
REQ-034 Three back-to-back programs -> LoadAddr 0, 256, 512 in order; ProgIdx sequence 0,1,2,0.
REQ-035 TIMEOUT=16'd20, Done never asserted -> FINISH after CycleCount=20, TimedOut=1, Ack pulse, ProgIdx advances.
REQ-036 TIMEOUT=16'd20, Done=1 on the cycle CycleCount reaches 20 -> TimedOut=0, CycleCount=20.
REQ-037 Reset asserted at RUN cycle 5 of program 1 -> next cycle IDLE, ProgIdx=0, CycleCount=0, FetchStart=1, no Ack.
REQ-038 Done pulsed in IDLE/HOLD and Go toggled during RUN -> no state change, no Ack, CycleCount unaffected.

Source files
------------

// File: rtl/prog_sequencer_if.sv
// Handshake and status bundle between the program sequencer and the core/fetch side.
// The master modport is the sequencer; the slave modport is the core it controls.
interface prog_sequencer_if;
   logic        go;
   logic        done;
   logic        fetch_start;
   logic        load_en;
   logic [9:0]  load_addr;
   logic [1:0]  prog_idx;
   logic        busy;
   logic        ack;
   logic [15:0] cycle_count;
   logic        timed_out;

   modport master (
      input  go, done,
      output fetch_start, load_en, load_addr, prog_idx, busy, ack, cycle_count, timed_out
   );

   modport slave (
      output go, done,
      input  fetch_start, load_en, load_addr, prog_idx, busy, ack, cycle_count, timed_out
   );
endinterface

// File: rtl/prog_sequencer.sv
// Launches three resident programs in rotation: load PC, hold until Go is released,
// run until Done or a cycle-limit timeout, then acknowledge and advance the index.
module prog_sequencer #(
   parameter logic [9:0]  BASE0   = 10'd0,
   parameter logic [9:0]  BASE1   = 10'd256,
   parameter logic [9:0]  BASE2   = 10'd512,
   parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
   input  logic               clk,
   input  logic               reset,
   prog_sequencer_if.master   bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      HOLD   = 3'd2,
      RUN    = 3'd3,
      FINISH = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  prog_idx_q, prog_idx_d;
   logic [15:0] cycle_count_q, cycle_count_d;
   logic        timed_out_q, timed_out_d;
   logic        fetch_start_q, fetch_start_d;
   logic        load_en_q, load_en_d;
   logic        busy_q, busy_d;
   logic        ack_q, ack_d;
   logic [9:0]  load_addr_s;

   // Next-state and next-output computation; outputs are registered from the next state.
   always_comb begin
      state_d       = state_q;
      prog_idx_d    = prog_idx_q;
      cycle_count_d = cycle_count_q;
      timed_out_d   = timed_out_q;
      case (state_q)
         IDLE: begin
            if (bus.go) state_d = LOAD;
            else        state_d = IDLE;
         end
         LOAD: begin
            state_d       = HOLD;
            cycle_count_d = 16'd0;
            timed_out_d   = 1'b0;
         end
         HOLD: begin
            if (bus.go) state_d = HOLD;
            else        state_d = RUN;
         end
         RUN: begin
            // Saturate at the limit so the count never wraps, even when Done coincides.
            if (cycle_count_q != TIMEOUT) cycle_count_d = cycle_count_q + 16'd1;
            else                          cycle_count_d = cycle_count_q;
            if (bus.done) begin
               state_d     = FINISH;
               timed_out_d = 1'b0;
            end else if (cycle_count_q == TIMEOUT) begin
               state_d     = FINISH;
               timed_out_d = 1'b1;
            end else begin
               state_d     = RUN;
            end
         end
         FINISH: begin
            state_d = IDLE;
            if (prog_idx_q >= 2'd2) prog_idx_d = 2'd0;
            else                    prog_idx_d = prog_idx_q + 2'd1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      fetch_start_d = (state_d != RUN);
      load_en_d     = (state_d == LOAD);
      busy_d        = (state_d != IDLE);
      ack_d         = (state_d == FINISH);
   end

   // Single state/output register bank with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         prog_idx_q    <= 2'd0;
         cycle_count_q <= 16'd0;
         timed_out_q   <= 1'b0;
         fetch_start_q <= 1'b1;
         load_en_q     <= 1'b0;
         busy_q        <= 1'b0;
         ack_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         prog_idx_q    <= prog_idx_d;
         cycle_count_q <= cycle_count_d;
         timed_out_q   <= timed_out_d;
         fetch_start_q <= fetch_start_d;
         load_en_q     <= load_en_d;
         busy_q        <= busy_d;
         ack_q         <= ack_d;
      end
   end

   // Base address decode; the unused index falls back to program 0.
   always_comb begin
      case (prog_idx_q)
         2'd0:    load_addr_s = BASE0;
         2'd1:    load_addr_s = BASE1;
         2'd2:    load_addr_s = BASE2;
         default: load_addr_s = BASE0;
      endcase
   end

   assign bus.fetch_start = fetch_start_q;
   assign bus.load_en     = load_en_q;
   assign bus.load_addr   = load_addr_s;
   assign bus.prog_idx    = prog_idx_q;
   assign bus.busy        = busy_q;
   assign bus.ack         = ack_q;
   assign bus.cycle_count = cycle_count_q;
   assign bus.timed_out   = timed_out_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed scoreboard bench for prog_sequencer: expected loads and completions are
// queued when a program is launched and checked when load_en / ack appear.
module tb_prog_sequencer;
   localparam logic [15:0] TMO = 16'd20;

   typedef struct {
      logic [15:0] cnt;
      logic        to;
   } res_t;

   logic clk;
   logic reset;
   prog_sequencer_if bus();

   prog_sequencer #(.TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int model_idx   = 0;
   res_t        res_q[$];
   logic [9:0]  addr_q[$];
   logic [1:0]  idx_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [9:0] base_of(input int idx);
      case (idx)
         1:       return 10'd256;
         2:       return 10'd512;
         default: return 10'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock, then scoreboard checks on whatever the DUT produced.
   task automatic tick();
      logic [9:0] a;
      logic [1:0] ix;
      res_t       r;
      @(posedge clk);
      #1;
      if (bus.load_en || bus.ack) chk("load_ack_excl", 32'(bus.load_en & bus.ack), 32'd0);
      if (bus.load_en) begin
         if (addr_q.size() == 0) begin
            chk("spurious_load", 32'(bus.load_en), 32'd0);
         end else begin
            a  = addr_q.pop_front();
            ix = idx_q.pop_front();
            chk("load_addr", 32'(bus.load_addr), 32'(a));
            chk("load_idx", 32'(bus.prog_idx), 32'(ix));
         end
      end
      if (bus.ack) begin
         if (res_q.size() == 0) begin
            chk("spurious_ack", 32'(bus.ack), 32'd0);
         end else begin
            r = res_q.pop_front();
            chk("ack_count", 32'(bus.cycle_count), 32'(r.cnt));
            chk("ack_timed_out", 32'(bus.timed_out), 32'(r.to));
            chk("ack_fetch_start", 32'(bus.fetch_start), 32'd1);
         end
      end
   endtask

   task automatic launch();
      addr_q.push_back(base_of(model_idx));
      idx_q.push_back(2'(model_idx));
      bus.go = 1'b1;
      tick();
      chk("load_busy", 32'(bus.busy), 32'd1);
      tick();
      chk("load_en_1cyc", 32'(bus.load_en), 32'd0);
      tick();
      chk("hold_frozen", 32'(bus.fetch_start), 32'd1);
      bus.go = 1'b0;
      tick();
      chk("run_fetch", 32'(bus.fetch_start), 32'd0);
      chk("run_count0", 32'(bus.cycle_count), 32'd0);
   endtask

   task automatic run_n(input int n, input bit toggle_go);
      for (int i = 0; i < n; i++) begin
         if (toggle_go) bus.go = ((i % 2) == 1);
         tick();
      end
      bus.go = 1'b0;
   endtask

   task automatic finish_prog(input bit with_done, input logic [15:0] exp_cnt, input logic exp_to);
      res_t r;
      bit   got;
      r.cnt = exp_cnt;
      r.to  = exp_to;
      res_q.push_back(r);
      bus.done = with_done;
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         tick();
         bus.done = 1'b0;
         if (bus.ack) got = 1'b1;
      end
      chk("ack_seen", 32'(got), 32'd1);
      tick();
      model_idx = (model_idx + 1) % 3;
      chk("ack_1cyc", 32'(bus.ack), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("prog_idx_adv", 32'(bus.prog_idx), 32'(model_idx));
      chk("count_held", 32'(bus.cycle_count), 32'(exp_cnt));
      chk("to_held", 32'(bus.timed_out), 32'(exp_to));
   endtask

   initial begin
      reset    = 1'b1;
      bus.go   = 1'b0;
      bus.done = 1'b0;
      tick();
      bus.go = 1'b1;
      tick();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_fetch", 32'(bus.fetch_start), 32'd1);
      chk("rst_load_en", 32'(bus.load_en), 32'd0);
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_addr", 32'(bus.load_addr), 32'd0);
      chk("rst_idx", 32'(bus.prog_idx), 32'd0);
      chk("rst_count", 32'(bus.cycle_count), 32'd0);
      chk("rst_to", 32'(bus.timed_out), 32'd0);
      bus.go = 1'b0;
      reset  = 1'b0;
      tick();

      // Program 0: Done on the 10th RUN cycle
      launch();
      run_n(9, 1'b0);
      finish_prog(1'b1, 16'd10, 1'b0);

      // Program 1: short run
      launch();
      run_n(2, 1'b0);
      finish_prog(1'b1, 16'd3, 1'b0);

      // Program 2: never done, runs into the limit
      launch();
      finish_prog(1'b0, TMO, 1'b1);

      // Program 0 again: Done exactly when the count sits at the limit
      launch();
      run_n(20, 1'b0);
      chk("at_limit_count", 32'(bus.cycle_count), 32'(TMO));
      chk("at_limit_busy", 32'(bus.busy), 32'd1);
      finish_prog(1'b1, TMO, 1'b0);

      // Program 1 aborted by reset at RUN cycle 5
      launch();
      run_n(5, 1'b0);
      chk("mid_run_count", 32'(bus.cycle_count), 32'd5);
      reset    = 1'b1;
      bus.done = 1'b1;
      bus.go   = 1'b1;
      tick();
      reset    = 1'b0;
      bus.done = 1'b0;
      bus.go   = 1'b0;
      model_idx = 0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_idx", 32'(bus.prog_idx), 32'd0);
      chk("abort_count", 32'(bus.cycle_count), 32'd0);
      chk("abort_fetch", 32'(bus.fetch_start), 32'd1);
      chk("abort_ack", 32'(bus.ack), 32'd0);
      chk("abort_addr", 32'(bus.load_addr), 32'd0);
      tick();
      chk("abort_stay_idle", 32'(bus.busy), 32'd0);

      // Done ignored in IDLE and HOLD, Go ignored in RUN
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      chk("idle_done_busy", 32'(bus.busy), 32'd0);
      chk("idle_done_ack", 32'(bus.ack), 32'd0);
      addr_q.push_back(base_of(model_idx));
      idx_q.push_back(2'(model_idx));
      bus.go = 1'b1;
      tick();
      tick();
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      chk("hold_done_busy", 32'(bus.busy), 32'd1);
      chk("hold_done_fetch", 32'(bus.fetch_start), 32'd1);
      chk("hold_done_ack", 32'(bus.ack), 32'd0);
      bus.go = 1'b0;
      tick();
      chk("run_after_hold", 32'(bus.fetch_start), 32'd0);
      chk("run_after_hold_count", 32'(bus.cycle_count), 32'd0);
      run_n(6, 1'b1);
      chk("go_toggle_count", 32'(bus.cycle_count), 32'd6);
      chk("go_toggle_fetch", 32'(bus.fetch_start), 32'd0);
      finish_prog(1'b1, 16'd7, 1'b0);

      chk("res_q_drained", 32'(res_q.size()), 32'd0);
      chk("addr_q_drained", 32'(addr_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
